// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants, slot state encoding and width helper for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

    // All segments off (active-low outputs).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Each digit slot opens with an anti-ghosting guard and then drives its digit.
    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } slotState_t;

    // Ceiling log2 with a floor of one bit, used to size counters.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_lut.sv
// Single-digit hex to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
module SEG7_LUT
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] iDIG,
    output logic [6:0] oSEG
);

    // Pure lookup; the caller registers the result.
    always_comb begin
        case (iDIG)
            4'h0:    oSEG = 7'h40;
            4'h1:    oSEG = 7'h79;
            4'h2:    oSEG = 7'h24;
            4'h3:    oSEG = 7'h30;
            4'h4:    oSEG = 7'h19;
            4'h5:    oSEG = 7'h12;
            4'h6:    oSEG = 7'h02;
            4'h7:    oSEG = 7'h78;
            4'h8:    oSEG = 7'h00;
            4'h9:    oSEG = 7'h18;
            4'hA:    oSEG = 7'h08;
            4'hB:    oSEG = 7'h03;
            4'hC:    oSEG = 7'h46;
            4'hD:    oSEG = 7'h21;
            4'hE:    oSEG = 7'h06;
            4'hF:    oSEG = 7'h0E;
            default: oSEG = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed NDIG-digit common-anode 7-segment scan controller with guard
// cycles, frame-synchronous double-buffered data, LZS, blanking and blinking.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int PRESCALE     = 12500,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 256
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [4*NDIG-1:0] iDATA,
    input  logic              iLOAD,
    output logic              oREADY,
    input  logic              iLZS,
    input  logic [NDIG-1:0]   iBLANK,
    input  logic [NDIG-1:0]   iBLINK,
    output logic [6:0]        oSEG,
    output logic [NDIG-1:0]   oAN,
    output logic              oFRAME
);

    localparam int CNT_W = clog2(PRESCALE);
    localparam int IDX_W = clog2(NDIG);
    localparam int BLK_W = clog2(BLINK_FRAMES);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GUARD_END  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] DIG_LAST   = IDX_W'(NDIG - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]  slotCnt;
    logic [IDX_W-1:0]  digIdx;
    logic [BLK_W-1:0]  blinkCnt;
    logic              blinkPhase;
    logic              pendVld;
    logic [4*NDIG-1:0] pending;
    logic [4*NDIG-1:0] shadow;

    slotState_t        slotState;
    logic [3:0]        curNib;
    logic [6:0]        lutSeg;
    logic [NDIG-1:0]   zeroFromTop;
    logic              allZero;
    logic              digBlank;
    logic [NDIG-1:0]   anDrive;

    assign oREADY = ~pendVld;

    // Slot phase decoded from the position inside the current digit slot.
    always_comb begin
        slotState = (slotCnt < GUARD_END) ? GUARD : DRIVE;
    end

    // Select the nibble of the digit being scanned and build its anode pattern.
    always_comb begin
        curNib          = shadow[{digIdx, 2'b00} +: 4];
        anDrive         = '1;
        anDrive[digIdx] = 1'b0;
    end

    // zeroFromTop[k] is set when every nibble from the top digit down to k is zero.
    always_comb begin
        zeroFromTop = '0;
        allZero     = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--) begin
            allZero        = allZero & (shadow[4*k +: 4] == 4'h0);
            zeroFromTop[k] = allZero;
        end
    end

    // Digit blanking: forced mask, blink off-phase, or leading zero (never digit 0).
    always_comb begin
        digBlank = iBLANK[digIdx]
                 | (iBLINK[digIdx] & blinkPhase)
                 | (iLZS & (digIdx != '0) & zeroFromTop[digIdx]);
    end

    SEG7_LUT uLut (
        .iDIG (curNib),
        .oSEG (lutSeg)
    );

    // Slot counter and digit index: wrap each slot, step to the next digit on wrap.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            slotCnt <= '0;
            digIdx  <= '0;
        end else if (slotCnt == SLOT_LAST) begin
            slotCnt <= '0;
            digIdx  <= (digIdx == DIG_LAST) ? '0 : digIdx + 1'b1;
        end else begin
            slotCnt <= slotCnt + 1'b1;
        end
    end

    // Registered display outputs: one cycle behind the counter/index state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oSEG   <= SEG_BLANK;
            oAN    <= '1;
            oFRAME <= 1'b0;
        end else begin
            oFRAME <= (slotCnt == SLOT_LAST) && (digIdx == DIG_LAST);
            case (slotState)
                GUARD: begin
                    oSEG <= SEG_BLANK;
                    oAN  <= '1;
                end
                DRIVE: begin
                    oSEG <= digBlank ? SEG_BLANK : lutSeg;
                    oAN  <= anDrive;
                end
                default: begin
                    oSEG <= SEG_BLANK;
                    oAN  <= '1;
                end
            endcase
        end
    end

    // Load handshake and frame-synchronous shadow update; a load taken in the
    // frame-end cycle itself waits for the next frame end.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pendVld <= 1'b0;
            pending <= '0;
            shadow  <= '0;
        end else if (oFRAME && pendVld) begin
            shadow  <= pending;
            pendVld <= 1'b0;
        end else if (iLOAD && !pendVld) begin
            pending <= iDATA;
            pendVld <= 1'b1;
        end
    end

    // Blink timebase: count frames, toggle the phase every BLINK_FRAMES frames.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (oFRAME) begin
            if (blinkCnt == BLINK_LAST) begin
                blinkCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCnt <= blinkCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected digit slots,
// a negedge monitor reconstructs each drive slot and compares it.
module tb_seg7_scan_ctrl;

    localparam int NDIG         = 4;
    localparam int PRESCALE     = 8;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic [4*NDIG-1:0] iDATA;
    logic              iLOAD;
    logic              oREADY;
    logic              iLZS;
    logic [NDIG-1:0]   iBLANK;
    logic [NDIG-1:0]   iBLINK;
    logic [6:0]        oSEG;
    logic [NDIG-1:0]   oAN;
    logic              oFRAME;

    seg7_scan_ctrl #(
        .NDIG         (NDIG),
        .PRESCALE     (PRESCALE),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iDATA  (iDATA),
        .iLOAD  (iLOAD),
        .oREADY (oREADY),
        .iLZS   (iLZS),
        .iBLANK (iBLANK),
        .iBLINK (iBLINK),
        .oSEG   (oSEG),
        .oAN    (oAN),
        .oFRAME (oFRAME)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } slotExp_t;

    slotExp_t expQ[$];
    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: rebuild each drive slot from the pins and score it.
    logic       inSlot = 1'b0;
    logic       havePrev = 1'b0;
    logic       haveFrame = 1'b0;
    logic       slotStable = 1'b1;
    logic       guardSegOk = 1'b1;
    logic [3:0] slotAn = 4'hF;
    logic [6:0] slotSeg = 7'h7F;
    int         slotLen = 0;
    int         guardLen = 0;
    int         cyc = 0;
    int         lastFrame = 0;

    always @(negedge iCLK) begin
        slotExp_t e;
        cyc++;
        if (oAN !== 4'hF) begin
            if (!inSlot) begin
                inSlot     = 1'b1;
                slotAn     = oAN;
                slotSeg    = oSEG;
                slotLen    = 1;
                slotStable = 1'b1;
                checkVal("anode one-hot", $countones(~oAN), 1);
                if (havePrev) begin
                    checkVal("guard width", guardLen, BLANK_CYC);
                    checkVal("guard segments off", {31'd0, guardSegOk}, 1);
                end
            end else begin
                slotLen++;
                if (oAN !== slotAn || oSEG !== slotSeg) slotStable = 1'b0;
            end
            guardLen   = 0;
            guardSegOk = 1'b1;
        end else begin
            if (inSlot) begin
                inSlot = 1'b0;
                if (!iRST && expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkVal("slot anode", {28'd0, slotAn}, {28'd0, e.an});
                    checkVal("slot segments", {25'd0, slotSeg}, {25'd0, e.seg});
                    checkVal("slot width", slotLen, PRESCALE - BLANK_CYC);
                    checkVal("slot stable", {31'd0, slotStable}, 1);
                end
                havePrev = 1'b1;
            end
            guardLen++;
            if (oSEG !== 7'h7F) guardSegOk = 1'b0;
        end
        if (oFRAME === 1'b1) begin
            if (haveFrame) checkVal("frame period", cyc - lastFrame, NDIG * PRESCALE);
            lastFrame = cyc;
            haveFrame = 1'b1;
        end
        if (iRST) begin
            inSlot     = 1'b0;
            havePrev   = 1'b0;
            haveFrame  = 1'b0;
            guardLen   = 0;
            guardSegOk = 1'b1;
        end
    end

    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    // Stops in the oFRAME cycle.
    task automatic waitFrameRaw();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            tick();
            if (oFRAME === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL frame timeout: no oFRAME within 200 cycles");
        end
    endtask

    // Stops in the first cycle of the next frame, after the monitor scored the old one.
    task automatic waitFrame();
        waitFrameRaw();
        tick();
    endtask

    task automatic pushFrame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        expQ.push_back('{an: 4'hE, seg: s0});
        expQ.push_back('{an: 4'hD, seg: s1});
        expQ.push_back('{an: 4'hB, seg: s2});
        expQ.push_back('{an: 4'h7, seg: s3});
    endtask

    task automatic loadWord(input logic [15:0] d);
        checkVal("ready before load", {31'd0, oREADY}, 1);
        iDATA = d;
        iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        checkVal("ready after load", {31'd0, oREADY}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        iRST   = 1'b1;
        iDATA  = '0;
        iLOAD  = 1'b0;
        iLZS   = 1'b0;
        iBLANK = '0;
        iBLINK = '0;
        repeat (3) tick();
        checkVal("reset oAN", {28'd0, oAN}, 32'hF);
        checkVal("reset oSEG", {25'd0, oSEG}, 32'h7F);
        checkVal("reset oREADY", {31'd0, oREADY}, 1);
        checkVal("reset oFRAME", {31'd0, oFRAME}, 0);

        // Blink on digit 0, data 0008; frame 0 still shows the cleared shadow.
        iRST   = 1'b0;
        iBLINK = 4'b0001;
        pushFrame(7'h40, 7'h40, 7'h40, 7'h40);
        loadWord(16'h0008);
        waitFrameRaw();
        checkVal("ready in frame-end cycle", {31'd0, oREADY}, 0);
        tick();
        checkVal("ready after frame end", {31'd0, oREADY}, 1);
        pushFrame(7'h00, 7'h40, 7'h40, 7'h40);
        waitFrame();
        pushFrame(7'h7F, 7'h40, 7'h40, 7'h40);
        waitFrame();
        pushFrame(7'h7F, 7'h40, 7'h40, 7'h40);
        waitFrame();
        pushFrame(7'h00, 7'h40, 7'h40, 7'h40);
        waitFrame();
        iBLINK = '0;

        // Plain decode of 1234.
        loadWord(16'h1234);
        waitFrameRaw();
        checkVal("ready held until frame end", {31'd0, oREADY}, 0);
        tick();
        checkVal("ready rises after frame end", {31'd0, oREADY}, 1);
        pushFrame(7'h19, 7'h30, 7'h24, 7'h79);
        waitFrame();

        // Second load while pending is full must be dropped.
        loadWord(16'hAAAA);
        iDATA = 16'h5555;
        iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        checkVal("ready after ignored load", {31'd0, oREADY}, 0);
        waitFrame();
        checkVal("ready after AAAA transfer", {31'd0, oREADY}, 1);
        pushFrame(7'h08, 7'h08, 7'h08, 7'h08);
        waitFrame();
        pushFrame(7'h08, 7'h08, 7'h08, 7'h08);
        waitFrame();

        // Leading-zero suppression.
        iLZS = 1'b1;
        loadWord(16'h0070);
        waitFrame();
        pushFrame(7'h40, 7'h78, 7'h7F, 7'h7F);
        waitFrame();
        loadWord(16'h0000);
        waitFrame();
        pushFrame(7'h40, 7'h7F, 7'h7F, 7'h7F);
        waitFrame();
        iLZS = 1'b0;

        // Forced blank on digit 1, sampled live.
        iBLANK = 4'b0010;
        pushFrame(7'h40, 7'h7F, 7'h40, 7'h40);
        waitFrame();
        iBLANK = '0;

        // Reset in the middle of digit 2's drive with a load pending.
        loadWord(16'hFFFF);
        waitFrame();
        loadWord(16'h1111);
        expQ.push_back('{an: 4'hE, seg: 7'h0E});
        expQ.push_back('{an: 4'hD, seg: 7'h0E});
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            tick();
            if (oAN === 4'hB) found = 1'b1;
        end
        checkVal("digit 2 drive reached", {31'd0, found}, 1);
        tick();
        tick();
        checkVal("ready low before reset", {31'd0, oREADY}, 0);
        iRST = 1'b1;
        tick();
        checkVal("mid-scan reset oAN", {28'd0, oAN}, 32'hF);
        checkVal("mid-scan reset oSEG", {25'd0, oSEG}, 32'h7F);
        checkVal("mid-scan reset oREADY", {31'd0, oREADY}, 1);
        checkVal("mid-scan reset oFRAME", {31'd0, oFRAME}, 0);
        tick();
        iRST = 1'b0;
        pushFrame(7'h40, 7'h40, 7'h40, 7'h40);
        waitFrame();
        pushFrame(7'h40, 7'h40, 7'h40, 7'h40);
        waitFrame();

        checkVal("expectation queue drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
